// File: rtl/muldiv_seq.sv
// muldiv_seq: shared sequential signed/unsigned multiply/divide unit feeding HI/LO.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply terminates once the
// remaining multiplier magnitude bits are all zero).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_next;

    logic               is_div;    // captured operation class
    logic [WIDTH-1:0]   mcand;     // |a|: multiplicand or dividend magnitude
    logic [WIDTH-1:0]   mplier;    // |b|: shifted right when multiplying, fixed divisor when dividing
    logic [2*WIDTH-1:0] acc;       // multiply: partial product; divide: {remainder, quotient/dividend}
    logic [CW-1:0]      count;     // CALC cycles completed
    logic               neg_res;   // product/quotient must be negated
    logic               neg_rem;   // remainder must be negated
    logic               dz_flag;   // current DONE is a divide-by-zero

    logic               in_signed, in_div, in_div_zero, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               early_out, calc_last;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Operand decode and per-cycle arithmetic terms
    always_comb begin
        in_signed   = ~op[0];
        in_div      = op[1];
        in_div_zero = in_div && (b == '0);
        a_neg       = in_signed & a[WIDTH-1];
        b_neg       = in_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
        early_out = !is_div && (mplier[WIDTH-1:1] == '0);
`else
        early_out = 1'b0;
`endif
        calc_last = early_out || (count == CW'(WIDTH - 1));

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, mplier};
        rem_sub   = rem_shift[WIDTH-1:0] - mplier;

`ifdef MULDIV_EARLY_OUT_EN
        // After k of WIDTH steps the product sits WIDTH-k bits too high.
        prod = acc >> (CW'(WIDTH) - count);
`else
        prod = acc;
`endif
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        div_zero   = (state == DONE) && dz_flag;
        case (state)
            IDLE:    if (start) state_next = in_div_zero ? DONE : CALC;
            CALC:    if (calc_last) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iterative shift-add / restoring divide, sign fix and HI/LO load
    always_ff @(posedge clock) begin
        if (reset) begin
            is_div  <= 1'b0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_flag <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dz_flag <= in_div_zero;
                        if (!in_div_zero) begin
                            is_div  <= in_div;
                            mcand   <= a_mag;
                            mplier  <= b_mag;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            count   <= '0;
                            acc     <= in_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        if (rem_ge) acc <= {rem_sub, acc[WIDTH-2:0], 1'b1};
                        else        acc <= {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        if (mplier[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
                        else           acc <= {1'b0, acc[2*WIDTH-1:1]};
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table, hand corner sequences and random ops against a
// plain-arithmetic reference model for muldiv_seq (WIDTH=32 and WIDTH=16).
module tb_muldiv_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, dz16;
    logic [15:0] hi16, lo16;

    int checks;
    int failures;
    logic [31:0] mh, ml;

    always #5 clock = ~clock;

    muldiv_seq #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_seq #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .div_zero(dz16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Cycles from the start cycle until done is visible.
    function automatic int lat_model(input int w, input logic [1:0] o, input logic [31:0] bb);
        logic [31:0] mask;
        logic [31:0] m;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        m = bb & mask;
        if (o[1]) return (m == 32'd0) ? 1 : w + 2;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            int n;
            if (o == 2'b00 && m[w-1]) m = ((~m) + 32'd1) & mask;
            n = 0;
            for (int i = 0; i < w; i++) if (m[i]) n = i + 1;
            return ((n < 1) ? 1 : n) + 2;
        end
`else
        return w + 2;
`endif
    endfunction

    // Reference: HI/LO hold their previous value on divide by zero.
    task automatic ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          inout logic [31:0] rh, inout logic [31:0] rl, output logic dz);
        longint      sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        dz = 1'b0;
        case (o)
            2'b00: begin sp = sx * sy; rh = sp[63:32]; rl = sp[31:0]; end
            2'b01: begin up = {32'd0, x} * {32'd0, y}; rh = up[63:32]; rl = up[31:0]; end
            2'b10: begin
                if (y == 32'd0) dz = 1'b1;
                else begin sq = sx / sy; sr = sx % sy; rl = sq[31:0]; rh = sr[31:0]; end
            end
            default: begin
                if (y == 32'd0) dz = 1'b1;
                else begin rl = x / y; rh = x % y; end
            end
        endcase
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input int elat);
        int lat;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!done) lat = -1;
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        check({tag, "_dz"}, div_zero, edz);
        @(posedge clock); #1;
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic run16(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] eh, input logic [15:0] el,
                         input int elat);
        int lat;
        start16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(posedge clock); #1;
        start16 = 1'b0;
        lat = 1;
        while (!done16 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!done16) lat = -1;
        check({tag, "_lat"}, lat, elat);
        check({tag, "_hi"}, hi16, eh);
        check({tag, "_lo"}, lo16, el);
        @(posedge clock); #1;
        check({tag, "_idle"}, busy16, 1'b0);
    endtask

    initial begin
        int          k;
        logic        seen, edz;
        logic [1:0]  ro;
        logic [31:0] rx, ry, got_hi, got_lo;

        checks = 0; failures = 0;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        mh = '0; ml = '0;

        vecs[0] = '{2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b11, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
        vecs[5] = '{2'b01, 32'd3,          32'd2,         32'd0,         32'd6,         1'b0};
        vecs[6] = '{2'b11, 32'd95,         32'd10,        32'd5,         32'd9,         1'b0};
        vecs[7] = '{2'b11, 32'd100,        32'd0,         32'd5,         32'd9,         1'b1};
        vecs[8] = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
        vecs[9] = '{2'b00, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy16", busy16, 1'b0);
        reset = 1'b0;
        @(posedge clock); #1;

        // start while busy is ignored; first result intact
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge clock); #1;
        start = 1'b0;
        k = 1; seen = 1'b0;
        while (k < 200) begin
            if (done) begin seen = 1'b1; break; end
            if (k == 5) begin start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd100; end
            @(posedge clock); #1;
            start = 1'b0;
            k++;
        end
        if (!seen) k = -1;
        got_hi = hi; got_lo = lo;
        ref_op(2'b00, 32'd5, 32'd6, mh, ml, edz);
        check("ign_lat", k, lat_model(32, 2'b00, 32'd6));
        check("ign_hi", got_hi, mh);
        check("ign_lo", got_lo, ml);
        @(posedge clock); #1;
        check("ign_idle", busy, 1'b0);

        // Reset mid-operation, with start held during reset
        start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h5678;
        @(posedge clock); #1;
        start = 1'b0;
        k = 1; seen = 1'b0;
        while (k < 10) begin
            if (done) seen = 1'b1;
            @(posedge clock); #1;
            k++;
        end
        reset = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
        @(posedge clock); #1;
        check("mid_busy", busy, 1'b0);
        check("mid_done", done, 1'b0);
        check("mid_hi", hi, 32'd0);
        check("mid_lo", lo, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        check("rststart_busy", busy, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (done) seen = 1'b1;
            @(posedge clock); #1;
        end
        check("mid_no_done", seen, 1'b0);
        mh = '0; ml = '0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            ref_op(vecs[i].op, vecs[i].a, vecs[i].b, mh, ml, edz);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, lat_model(32, vecs[i].op, vecs[i].b));
        end

        // 16-bit instance: latency scales with WIDTH
        run16("w16_multu", 2'b01, 16'd3, 16'd2, 16'd0, 16'd6, lat_model(16, 2'b01, 32'd2));
        run16("w16_divovf", 2'b10, 16'h8000, 16'hFFFF, 16'd0, 16'h8000, 18);
        run16("w16_mult", 2'b00, 16'hFFFF, 16'hFFFF, 16'd0, 16'd1, lat_model(16, 2'b00, 32'h0000_FFFF));

        // Random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1, 2:    ry = 32'($urandom_range(0, 15));
                3:       ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 14));
                default: ry = 32'($urandom);
            endcase
            ref_op(ro, rx, ry, mh, ml, edz);
            run_op("rand", ro, rx, ry, mh, ml, edz, lat_model(32, ro, ry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
